// File: rtl/multi_reg_sequencer_pkg.sv
// Shared definitions for the LDM/STM register-list sequencer and the
// multi-register encoder that consumes its one-hot word.
package multi_reg_sequencer_pkg;

   typedef enum logic [1:0] {StIdle, StRun, StDone} seqStateT;

   localparam logic [31:0] WORD_BYTES   = 32'd4;
   localparam int unsigned REG_LIST_LSB = 16;

   // Addressing modes encoded as {Up, Pre}
   localparam logic [1:0] MODE_DA = 2'b00;
   localparam logic [1:0] MODE_DB = 2'b01;
   localparam logic [1:0] MODE_IA = 2'b10;
   localparam logic [1:0] MODE_IB = 2'b11;

   function automatic logic [4:0] popCount(input logic [15:0] vec);
      logic [4:0] cnt;
      cnt = '0;
      for (int i = 0; i < 16; i++) begin
         cnt = cnt + {4'd0, vec[i]};
      end
      return cnt;
   endfunction

endpackage

// File: rtl/multi_reg_sequencer_lsb_pick.sv
// Combinational lowest-set-bit selector: isolates the lowest set bit of a
// 16-bit vector and reports its index and whether any bit was set.
module multi_reg_sequencer_lsb_pick (
   input  logic [15:0] vec,
   output logic [15:0] oneHot,
   output logic [3:0]  index,
   output logic        found
);

   always_comb begin
      oneHot = vec & (~vec + 16'd1);
      found  = |vec;
      index  = 4'd0;
      // Scan downwards so the lowest set bit wins
      for (int i = 15; i >= 0; i--) begin
         if (vec[i]) begin
            index = 4'(i);
         end
      end
   end

endmodule

// File: rtl/multi_reg_sequencer.sv
// Walks an LDM/STM register list lowest register first, presenting one
// transfer per handshake along with its address and the base writeback value.
module multi_reg_sequencer
   import multi_reg_sequencer_pkg::*;
(
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Start,
   input  logic [15:0] RegList,
   input  logic [31:0] Base,
   input  logic        Up,
   input  logic        Pre,
   input  logic        Next,
   output logic        Busy,
   output logic        Valid,
   output logic [31:0] OneHot,
   output logic [3:0]  RegNum,
   output logic [31:0] Addr,
   output logic        Last,
   output logic        Done,
   output logic [31:0] WbAddr,
   output logic [4:0]  Count
);

   seqStateT    stateQ, stateD;
   logic [15:0] pendingQ, pendingD;
   logic [31:0] addrQ, addrD;
   logic [31:0] wbAddrQ, wbAddrD;
   logic [4:0]  countQ, countD;

   logic [15:0] curOneHot;
   logic [3:0]  curIndex;
   logic        curFound;
   logic [15:0] restOneHot;
   logic [3:0]  restIndex;
   logic        restFound;
   logic        isLast;

   logic [4:0]  listCount;
   logic [31:0] listBytes;

   multi_reg_sequencer_lsb_pick uPickCur (
      .vec    (pendingQ),
      .oneHot (curOneHot),
      .index  (curIndex),
      .found  (curFound)
   );

   // Second picker sees the list with the current bit removed; if nothing is
   // left, the current transfer is the final one.
   multi_reg_sequencer_lsb_pick uPickRest (
      .vec    (pendingQ & ~curOneHot),
      .oneHot (restOneHot),
      .index  (restIndex),
      .found  (restFound)
   );

   assign isLast    = curFound & ~restFound;
   assign listCount = popCount(RegList);
   assign listBytes = {27'd0, listCount} * WORD_BYTES;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         stateQ   <= StIdle;
         pendingQ <= '0;
         addrQ    <= '0;
         wbAddrQ  <= '0;
         countQ   <= '0;
      end else begin
         stateQ   <= stateD;
         pendingQ <= pendingD;
         addrQ    <= addrD;
         wbAddrQ  <= wbAddrD;
         countQ   <= countD;
      end
   end

   always_comb begin
      stateD   = stateQ;
      pendingD = pendingQ;
      addrD    = addrQ;
      wbAddrD  = wbAddrQ;
      countD   = countQ;

      unique case (stateQ)
         StIdle: begin
            if (Start) begin
               pendingD = RegList;
               countD   = listCount;
               wbAddrD  = Up ? (Base + listBytes) : (Base - listBytes);
               // Every mode walks upwards, so decrementing modes start low
               unique case ({Up, Pre})
                  MODE_IA: addrD = Base;
                  MODE_IB: addrD = Base + WORD_BYTES;
                  MODE_DA: addrD = Base - listBytes + WORD_BYTES;
                  MODE_DB: addrD = Base - listBytes;
               endcase
               stateD = (listCount != 5'd0) ? StRun : StDone;
            end
         end
         StRun: begin
            if (Next) begin
               pendingD = pendingQ & ~curOneHot;
               addrD    = addrQ + WORD_BYTES;
               if (isLast) begin
                  stateD = StDone;
               end
            end
         end
         StDone: begin
            stateD = StIdle;
         end
         default: begin
            stateD = StIdle;
         end
      endcase
   end

   assign Valid  = (stateQ == StRun);
   assign Busy   = (stateQ != StIdle);
   assign Done   = (stateQ == StDone);
   assign Last   = Valid & isLast;
   assign RegNum = Valid ? curIndex : 4'd0;
   assign OneHot = Valid ? ({16'd0, curOneHot} << REG_LIST_LSB) : 32'd0;
   assign Addr   = addrQ;
   assign WbAddr = wbAddrQ;
   assign Count  = countQ;

endmodule
